// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - memory-stage load/store controller for the adapter data port
// One request at a time: checks, one adapter access with timeout, one-cycle done pulse.

module data_mem_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        req_store,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err,
    output logic [31:0] rdata,
    output logic        mem_re,
    output logic [3:0]  mem_we,
    output logic [6:0]  mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout,
    input  logic        mem_dready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WAIT,
        S_WR_PULSE,
        S_WR_WAIT,
        S_RECOVER
    } state_t;

    localparam logic [4:0] TO_CNT = 5'(TIMEOUT);

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ALIGN   = 2'b01;
    localparam logic [1:0] ERR_RANGE   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [8:0]  addr_q, addr_d;
    logic [3:0]  we_q, we_d;
    logic [31:0] din_q, din_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic [1:0]  err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    // Request decode, evaluated on the raw request inputs while idle
    logic        op_legal;
    logic        misaligned;
    logic        out_of_range;
    logic [3:0]  store_we;
    logic [31:0] store_din;

    always_comb begin
        op_legal     = 1'b0;
        misaligned   = 1'b0;
        out_of_range = |req_addr[31:9];
        store_we     = 4'b0000;
        store_din    = 32'h0;

        if (req_store) begin
            op_legal = (req_op <= 3'b010);
        end else begin
            op_legal = (req_op == 3'b000) || (req_op == 3'b001) || (req_op == 3'b010) ||
                       (req_op == 3'b100) || (req_op == 3'b101);
        end

        case (req_op[1:0])
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = (req_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase

        case (req_op[1:0])
            2'b00: begin
                store_we  = 4'b0001 << req_addr[1:0];
                store_din = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                store_we  = req_addr[1] ? 4'b1100 : 4'b0011;
                store_din = {2{req_wdata[15:0]}};
            end
            default: begin
                store_we  = 4'b1111;
                store_din = req_wdata;
            end
        endcase
    end

    // Lane extraction and extension of the returned word, using the latched request
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_ext;

    always_comb begin
        load_byte = 8'h0;
        load_half = addr_q[1] ? mem_dout[31:16] : mem_dout[15:0];
        load_ext  = 32'h0;

        case (addr_q[1:0])
            2'b00:   load_byte = mem_dout[7:0];
            2'b01:   load_byte = mem_dout[15:8];
            2'b10:   load_byte = mem_dout[23:16];
            default: load_byte = mem_dout[31:24];
        endcase

        case (op_q)
            3'b000:  load_ext = {{24{load_byte[7]}}, load_byte};
            3'b001:  load_ext = {{16{load_half[15]}}, load_half};
            3'b010:  load_ext = mem_dout;
            3'b100:  load_ext = {24'h0, load_byte};
            3'b101:  load_ext = {16'h0, load_half};
            default: load_ext = 32'h0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        we_d    = we_q;
        din_d   = din_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = err_q;
        rdata_d = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    op_d   = req_op;
                    addr_d = req_addr[8:0];
                    if (!op_legal || misaligned) begin
                        state_d = S_RECOVER;
                        done_d  = 1'b1;
                        err_d   = ERR_ALIGN;
                        rdata_d = 32'h0;
                    end else if (out_of_range) begin
                        state_d = S_RECOVER;
                        done_d  = 1'b1;
                        err_d   = ERR_RANGE;
                        rdata_d = 32'h0;
                    end else if (req_store) begin
                        state_d = S_WR_PULSE;
                        we_d    = store_we;
                        din_d   = store_din;
                    end else begin
                        state_d = S_RD_WAIT;
                        cnt_d   = 5'd0;
                    end
                end
            end

            S_RD_WAIT: begin
                if (mem_dready) begin
                    state_d = S_RECOVER;
                    done_d  = 1'b1;
                    err_d   = ERR_OK;
                    rdata_d = load_ext;
                end else if (cnt_q == TO_CNT) begin
                    state_d = S_RECOVER;
                    done_d  = 1'b1;
                    err_d   = ERR_TIMEOUT;
                    rdata_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end

            S_WR_PULSE: begin
                state_d = S_WR_WAIT;
                cnt_d   = 5'd0;
            end

            S_WR_WAIT: begin
                if (mem_dready) begin
                    state_d = S_RECOVER;
                    done_d  = 1'b1;
                    err_d   = ERR_OK;
                    rdata_d = 32'h0;
                end else if (cnt_q == TO_CNT) begin
                    state_d = S_RECOVER;
                    done_d  = 1'b1;
                    err_d   = ERR_TIMEOUT;
                    rdata_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end

            // One idle cycle with mem_re low so the adapter restarts its read delay
            S_RECOVER: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= 3'b000;
            addr_q  <= 9'h0;
            we_q    <= 4'b0000;
            din_q   <= 32'h0;
            cnt_q   <= 5'd0;
            done_q  <= 1'b0;
            err_q   <= ERR_OK;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            din_q   <= din_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign err      = err_q;
    assign rdata    = rdata_q;
    assign mem_re   = (state_q == S_RD_WAIT);
    assign mem_we   = (state_q == S_WR_PULSE) ? we_q : 4'b0000;
    assign mem_addr = addr_q[8:2];
    assign mem_din  = din_q;

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Memory-stage access controller between the CPU pipeline and the data port of the memory adapter. It accepts one load/store request at a time and performs alignment and range checks. It drives the adapter's data-port read enable, byte write enables, word address and write data, and waits for the data-ready handshake. It returns sign- or zero-extended load data with a one-cycle done pulse, and holds the pipeline busy meanwhile.

## Interface
- TIMEOUT, 16: cycles waited for mem_dready before the access is aborted (2..31).
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req  in  1  request strobe, sampled only in IDLE
- req_store  in  1  1 = store, 0 = load
- req_op  in  3  loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores: 000 SB, 001 SH, 010 SW
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle completion pulse
- err  out  2  valid with done: 00 ok, 01 misaligned/illegal op, 10 out of range, 11 timeout
- rdata  out  32  extended load data, valid with done, held until next done
- mem_re  out  1  to adapter reb
- mem_we  out  4  to adapter web, bit i = byte lane i (bits 8i+7:8i)
- mem_addr  out  7  to adapter addrb, = req_addr[8:2]
- mem_din  out  32  to adapter dinb
- mem_dout  in  32  from adapter doutb
- mem_dready  in  1  from adapter dreadyb

## Operation
- Byte order is little-endian: lane = addr[1:0].
- States: IDLE, RD_WAIT, WR_PULSE, WR_WAIT, RECOVER.
- IDLE with req=1: latch op, addr, wdata. Checks, in priority order:
  - Illegal op (load 011/110/111, store >010), or misaligned (H with addr[0]=1, W with addr[1:0]≠0) → err 01.
  - addr[31:9]≠0 → err 10.
  - Any error → RECOVER with done=1, no memory access.
- Valid load → RD_WAIT: mem_re=1, mem_addr held. On mem_dready=1 → RECOVER.
  - rdata: LB/LBU take lane addr[1:0], LH/LHU take halfword addr[1], LW takes the full word.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Valid store → WR_PULSE for exactly one cycle:
  - mem_we: SB = 1<<addr[1:0]; SH = 0011 or 1100 by addr[1]; SW = 1111.
  - mem_din: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
  - Then WR_WAIT with mem_we=0000, mem_din held. On mem_dready → RECOVER.
- Timeout counter:
  - 5 bits, cleared on entry to RD_WAIT/WR_WAIT, increments each cycle there.
  - On reaching TIMEOUT without dready → RECOVER, err 11, rdata=0.
- RECOVER lasts one cycle:
  - done=1, mem_re=0, mem_we=0, busy=1.
  - The low mem_re guarantees the adapter's read-delay counter restarts.
  - Then IDLE.
- req while busy is ignored (not queued).
- mem_dready seen outside RD_WAIT/WR_WAIT is ignored.

## Timing
- Reset values: state IDLE, busy 0, done 0, err 00, rdata 0, mem_re 0, mem_we 0000, mem_addr 0, mem_din 0, timeout counter 0.
- rst during any state aborts the access within the same edge. No done is produced.
- Load, cycle 0 = req sampled:
  - Cycles 1.. : mem_re=1.
  - Adapter asserts mem_dready in cycle 4.
  - Cycle 5: done, rdata valid.
  - Cycle 6: IDLE, next req accepted.
- Store: cycle 1 mem_we≠0, cycle 2 mem_dready, cycle 3 done, cycle 4 IDLE.
- Error request: done+err in cycle 1, IDLE in cycle 2.
- Back-to-back throughput: one load per 6 cycles, one store per 4 cycles.
- done and err are registered outputs; rdata updates on the same edge as done rises.

## Test plan
- Store SW 0x12345678 at 0x10, then LW 0x10 → mem_we=1111 in cycle 1, addr 0x04, done cycle 3; load done cycle 5, rdata 0x12345678, err 00.
- SB 0x80 at 0x13, then LB 0x13 and LBU 0x13 → mem_we=1000, mem_din 0x80808080; LB rdata 0xFFFFFF80, LBU 0x00000080.
- SH 0xBEEF at 0x22, then LH/LHU 0x22 → mem_we=1100; rdata 0xFFFFBEEF / 0x0000BEEF.
- LW at 0x02, LH at 0x01, load op 011, SW at 0x200 → done cycle 1, err 01, 01, 01, 10; mem_re and mem_we never asserted.
- Memory model never asserts dready, TIMEOUT=16 → done with err 11 in cycle 18, rdata 0, mem_re low in cycle 18.
- rst pulsed in cycle 2 of a load; req asserted during busy → all outputs at reset values next cycle, no done; a req ignored while busy produces no access.
